// File: rtl/avalon_acc_engine.sv
// avalon_acc_engine: Avalon-MM slave with NCHAN accumulator channels.
// Each channel: ACC (RW), ADD (W), SUB (W), STATUS (RW1C carry/borrow).
// Ports:
//   clk_i, rst_i (async, active-high)
//   address_i, byteenable_i, read_i, write_i, writedata_i
//   waitrequest_o, readdatavalid_o, readdata_o
module avalon_acc_engine #(
    parameter int unsigned NCHAN        = 3,
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned DATASIZE     = 16,
    parameter int unsigned OP_CYCLES    = 3,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ERRNO        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDRSIZE-1:0]   address_i,
    input  logic [DATASIZE/8-1:0] byteenable_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [DATASIZE-1:0]   writedata_i,
    output logic                  waitrequest_o,
    output logic                  readdatavalid_o,
    output logic [DATASIZE-1:0]   readdata_o
);
    localparam int unsigned CW    = ADDRSIZE - 2;
    localparam int unsigned NB    = DATASIZE / 8;
    localparam int unsigned EXTRA = (ERRNO == 3) ? 1 : 0;
    localparam logic [15:0] RDV_AT  = 16'(READ_LATENCY - 1 + EXTRA);
    localparam logic [15:0] RD_END  = 16'(READ_LATENCY + EXTRA);
    localparam logic [15:0] OP_LAST = 16'(OP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OP_BUSY, READ_WAIT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_cnt;
    logic [DATASIZE-1:0] r_acc  [NCHAN];
    logic [DATASIZE-1:0] r_opnd [NCHAN];
    logic [1:0]          r_stat [NCHAN];
    logic                r_op_sub;
    logic [CW-1:0]       r_op_chan;
    logic [DATASIZE-1:0] r_op_data;
    logic [DATASIZE-1:0] r_rdata;

    logic [CW-1:0]       w_chan;
    logic [1:0]          w_reg;
    logic [DATASIZE-1:0] w_mask;
    logic [DATASIZE-1:0] w_wdm;
    logic                w_accept;
    logic                w_in_range;
    logic                w_arith;
    logic                w_op_done;
    logic [DATASIZE-1:0] w_rd_val;
    logic [DATASIZE-1:0] w_cur;
    logic [DATASIZE:0]   w_sum;
    logic [DATASIZE-1:0] w_dif;
    logic                w_borrow;

    assign w_chan     = address_i[ADDRSIZE-1:2];
    assign w_reg      = address_i[1:0];
    assign w_wdm      = writedata_i & w_mask;
    assign w_accept   = (read_i | write_i) && (r_state == IDLE);
    assign w_in_range = 32'(w_chan) < NCHAN;
    assign w_arith    = write_i && w_in_range &&
                        ((w_reg == 2'd1) || (w_reg == 2'd2));
    assign w_op_done  = (r_state == OP_BUSY) && (r_cnt == 16'd0);

    always_comb begin
        w_mask = '0;
        for (int unsigned b = 0; b < NB; b++)
            w_mask[b*8 +: 8] = {8{byteenable_i[b]}};
    end

    // Read mux; out-of-range channels fall through to 0.
    always_comb begin
        w_rd_val = '0;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (w_chan == CW'(c)) begin
                case (w_reg)
                    2'd0:       w_rd_val = r_acc[c];
                    2'd1, 2'd2: w_rd_val = r_opnd[c];
                    default:    w_rd_val = {{(DATASIZE-2){1'b0}}, r_stat[c]};
                endcase
            end
        end
    end

    // Pending ADD/SUB arithmetic on the captured channel.
    always_comb begin
        w_cur = '0;
        for (int unsigned c = 0; c < NCHAN; c++)
            if (r_op_chan == CW'(c)) w_cur = r_acc[c];
        w_sum    = {1'b0, w_cur} + {1'b0, r_op_data};
        w_dif    = w_cur - r_op_data;
        w_borrow = r_op_data > w_cur;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (write_i) w_next = w_arith ? OP_BUSY : IDLE;
                    else         w_next = READ_WAIT;
                end
            end
            OP_BUSY:   if (r_cnt == 16'd0) w_next = IDLE;
            READ_WAIT: if (r_cnt == RD_END) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        waitrequest_o   = (r_state != IDLE);
        readdatavalid_o = (r_state == READ_WAIT) && (r_cnt == RDV_AT);
        readdata_o      = readdatavalid_o ? r_rdata : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_op_sub  <= 1'b0;
            r_op_chan <= '0;
            r_op_data <= '0;
            r_rdata   <= '0;
            for (int unsigned c = 0; c < NCHAN; c++) begin
                r_acc[c]  <= '0;
                r_opnd[c] <= '0;
                r_stat[c] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE:      if (w_accept) r_cnt <= w_arith ? OP_LAST : '0;
                OP_BUSY:   if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                READ_WAIT: r_cnt <= r_cnt + 16'd1;
                default:   r_cnt <= '0;
            endcase

            if (w_accept && write_i) begin
                r_op_sub  <= (w_reg == 2'd2);
                r_op_chan <= w_chan;
                r_op_data <= w_wdm;
                for (int unsigned c = 0; c < NCHAN; c++) begin
                    if (w_chan == CW'(c)) begin
                        case (w_reg)
                            2'd0: begin
                                if (ERRNO == 2) r_acc[c] <= writedata_i;
                                else r_acc[c] <= (r_acc[c] & ~w_mask) | w_wdm;
                            end
                            2'd1, 2'd2: r_opnd[c] <= w_wdm;
                            default: r_stat[c] <= r_stat[c] & ~w_wdm[1:0];
                        endcase
                    end
                end
            end else if (w_accept) begin
                r_rdata <= w_rd_val;
            end

            if (w_op_done) begin
                for (int unsigned c = 0; c < NCHAN; c++) begin
                    if (r_op_chan == CW'(c)) begin
                        if (r_op_sub) begin
                            r_acc[c] <= w_dif;
                            if (w_borrow && (ERRNO != 1)) r_stat[c][1] <= 1'b1;
                        end else begin
                            r_acc[c] <= w_sum[DATASIZE-1:0];
                            if (w_sum[DATASIZE]) r_stat[c][0] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_avalon_acc_engine.sv
// tb_avalon_acc_engine: scoreboard bench for avalon_acc_engine.
// Directed register-map cases, mid-op reset, then randomized traffic.
module tb_avalon_acc_engine;
    localparam int NCHAN        = 3;
    localparam int ADDRSIZE     = 4;
    localparam int DATASIZE     = 16;
    localparam int OP_CYCLES    = 3;
    localparam int READ_LATENCY = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  address_i = '0;
    logic [1:0]  byteenable_i = '0;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [15:0] writedata_i = '0;
    logic        waitrequest_o;
    logic        readdatavalid_o;
    logic [15:0] readdata_o;

    avalon_acc_engine #(
        .NCHAN(NCHAN), .ADDRSIZE(ADDRSIZE), .DATASIZE(DATASIZE),
        .OP_CYCLES(OP_CYCLES), .READ_LATENCY(READ_LATENCY), .ERRNO(0)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i),
        .byteenable_i(byteenable_i), .read_i(read_i), .write_i(write_i),
        .writedata_i(writedata_i), .waitrequest_o(waitrequest_o),
        .readdatavalid_o(readdatavalid_o), .readdata_o(readdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          compared = 0;
    int          failed = 0;
    int          cyc = 0;
    logic [15:0] m_acc  [NCHAN];
    logic [15:0] m_opnd [NCHAN];
    logic [1:0]  m_stat [NCHAN];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCHAN; c++) begin
            m_acc[c] = '0;
            m_opnd[c] = '0;
            m_stat[c] = '0;
        end
    endfunction

    function automatic logic [15:0] be_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
        int ch;
        ch = int'(a[3:2]);
        if (ch >= NCHAN) return 16'h0;
        case (a[1:0])
            2'd0:       return m_acc[ch];
            2'd1, 2'd2: return m_opnd[ch];
            default:    return {14'b0, m_stat[ch]};
        endcase
    endfunction

    // Returns the busy cycles the write should cost.
    function automatic int model_write(input logic [3:0] a,
                                       input logic [15:0] d,
                                       input logic [1:0] be);
        int ch;
        int sum;
        logic [15:0] m;
        logic [15:0] op;
        ch = int'(a[3:2]);
        m = be_mask(be);
        op = d & m;
        if (ch >= NCHAN) return 0;
        case (a[1:0])
            2'd0: begin
                m_acc[ch] = (m_acc[ch] & ~m) | op;
                return 0;
            end
            2'd1: begin
                m_opnd[ch] = op;
                sum = int'(m_acc[ch]) + int'(op);
                if (sum > 65535) m_stat[ch][0] = 1'b1;
                m_acc[ch] = 16'(sum % 65536);
                return OP_CYCLES;
            end
            2'd2: begin
                m_opnd[ch] = op;
                if (op > m_acc[ch]) m_stat[ch][1] = 1'b1;
                sum = int'(m_acc[ch]) - int'(op) + 65536;
                m_acc[ch] = 16'(sum % 65536);
                return OP_CYCLES;
            end
            default: begin
                m_stat[ch] = m_stat[ch] & ~op[1:0];
                return 0;
            end
        endcase
    endfunction

    task automatic xfer(input logic rd, input logic [3:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] e, output int busy);
        int guard;
        guard = 0;
        busy = 0;
        @(negedge clk_i);
        address_i = a;
        writedata_i = d;
        byteenable_i = be;
        read_i = rd;
        write_i = ~rd;
        while (waitrequest_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) begin
            compared++;
            failed++;
            $display("FAIL accept_timeout: addr %0h never accepted", a);
        end
        if (rd) sb_q.push_back('{e, cyc});
        @(posedge clk_i);
        #1;
        read_i = 1'b0;
        write_i = 1'b0;
        guard = 0;
        while (guard < 50) begin
            @(negedge clk_i);
            if (!waitrequest_o) break;
            busy++;
            guard++;
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d,
                            input logic [1:0] be);
        int busy;
        int exp_busy;
        exp_busy = model_write(a, d, be);
        xfer(1'b0, a, d, be, 16'h0, busy);
        check($sformatf("wr_busy@%0h", a), busy, exp_busy);
    endtask

    task automatic do_read(input logic [3:0] a, input logic use_k,
                           input logic [15:0] k);
        int busy;
        logic [15:0] e;
        e = use_k ? k : model_read(a);
        xfer(1'b1, a, 16'h0, 2'b11, e, busy);
        check($sformatf("rd_busy@%0h", a), busy, READ_LATENCY + 1);
    endtask

    // Monitor: pops expected read data on every readdatavalid pulse.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            if (readdatavalid_o) begin
                if (sb_q.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL rdv_unexpected: data %0h", readdata_o);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_data", readdata_o, e.data);
                    check("rd_latency", cyc - e.cyc, READ_LATENCY);
                end
            end else begin
                check("rdata_idle_zero", readdata_o, 16'h0);
            end
        end
    end

    initial begin
        int busy;
        logic [3:0] a;
        model_reset();
        #1;
        check("rst_wreq", waitrequest_o, 1'b0);
        check("rst_rdv", readdatavalid_o, 1'b0);
        check("rst_rdata", readdata_o, 16'h0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        do_read(4'h0, 1'b1, 16'h0000);

        do_write(4'h4, 16'h1234, 2'b11);
        do_write(4'h5, 16'h0010, 2'b11);
        do_read(4'h4, 1'b1, 16'h1244);
        do_read(4'h5, 1'b1, 16'h0010);

        do_write(4'h8, 16'hFFFF, 2'b11);
        do_write(4'h8, 16'hAB00, 2'b10);
        do_read(4'h8, 1'b1, 16'hABFF);
        do_write(4'h9, 16'h1234, 2'b01);
        do_read(4'h8, 1'b1, 16'hAC33);

        do_write(4'h0, 16'hFFFE, 2'b11);
        do_write(4'h1, 16'h0003, 2'b11);
        do_read(4'h0, 1'b1, 16'h0001);
        do_read(4'h3, 1'b1, 16'h0001);
        do_write(4'h2, 16'h0002, 2'b11);
        do_read(4'h0, 1'b1, 16'hFFFF);
        do_read(4'h3, 1'b1, 16'h0003);
        do_write(4'h3, 16'h0001, 2'b11);
        do_read(4'h3, 1'b1, 16'h0002);

        do_write(4'hC, 16'h5555, 2'b11);
        do_write(4'hD, 16'h5555, 2'b11);
        do_read(4'hD, 1'b1, 16'h0000);
        do_read(4'h0, 1'b1, 16'hFFFF);
        do_read(4'h4, 1'b1, 16'h1244);
        do_read(4'h8, 1'b1, 16'hAC33);

        // ADD in flight, reset lands in its second busy cycle.
        xfer(1'b0, 4'h5, 16'h0001, 2'b11, 16'h0, busy);
        do_write(4'h5, 16'h0001, 2'b11);
        @(negedge clk_i);
        address_i = 4'h1;
        writedata_i = 16'h0007;
        byteenable_i = 2'b11;
        write_i = 1'b1;
        @(posedge clk_i);
        #1;
        write_i = 1'b0;
        @(posedge clk_i);
        #2;
        check("busy_before_rst", waitrequest_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check("wreq_on_rst", waitrequest_o, 1'b0);
        check("rdv_on_rst", readdatavalid_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        do_read(4'h0, 1'b1, 16'h0000);
        do_read(4'h4, 1'b1, 16'h0000);
        do_read(4'h8, 1'b1, 16'h0000);
        do_read(4'h3, 1'b1, 16'h0000);
        do_read(4'h5, 1'b1, 16'h0000);

        for (int i = 0; i < 200; i++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                do_write(a, 16'($urandom), 2'($urandom_range(0, 3)));
            else
                do_read(a, 1'b0, 16'h0);
        end

        repeat (5) @(negedge clk_i);
        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, failed);
        $finish;
    end
endmodule

// File: doc/avalon_acc_engine.md
Name: avalon_acc_engine

Overview:
Parametrised Avalon-MM slave holding NCHAN independent accumulator channels. Each channel has direct-load, add and subtract registers plus a sticky carry/borrow status register. It is the successor to the fixed-size avalon_computer DUT. It adds multi-cycle arithmetic (waitrequest back-pressure), configurable read latency, byteenable masking and ERRNO-selectable injected faults for bench qualification. It is driven by the DPI-C Avalon master bench tasks.

Parameters:
NCHAN, 3, number of accumulator channels; constraint 4*NCHAN <= 2**ADDRSIZE
ADDRSIZE, 4, address width in words
DATASIZE, 16, data width; must be a multiple of 8
OP_CYCLES, 3, busy cycles per ADD/SUB; >=1
READ_LATENCY, 2, cycles from read acceptance to readdatavalid; >=1
ERRNO, 0, fault injection: 0 none, 1 borrow flag never set, 2 byteenable ignored on ACC write, 3 readdatavalid one cycle late

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
address_i  in  ADDRSIZE  word address: chan=address_i[ADDRSIZE-1:2], reg=address_i[1:0]
byteenable_i  in  DATASIZE/8  byte lanes
read_i  in  1  read request
write_i  in  1  write request
writedata_i  in  DATASIZE  write data
waitrequest_o  out  1  slave stall
readdatavalid_o  out  1  one-cycle read data strobe
readdata_o  out  DATASIZE  read data; 0 when readdatavalid_o=0

Behaviour:
- Reset (asynchronous, active-high rst_i): all outputs 0; all ACC, last-operand and status registers 0; FSM to IDLE; counter 0.
- Reset mid-operation: pending op/read discarded; no readdatavalid pulse.
- FSM states:
  - IDLE: waitrequest_o=0.
  - OP_BUSY: waitrequest_o=1 for exactly OP_CYCLES cycles.
  - READ_WAIT: waitrequest_o=1 for READ_LATENCY+1 cycles.
- Acceptance: a request is accepted on a rising edge with (read_i|write_i)=1 and waitrequest_o=0. Address, data and byteenable are captured at that edge.
- Simultaneous read_i and write_i: write serviced, read ignored (master protocol violation).
- Register map per channel:
  - reg0 ACC (RW): write loads enabled bytes only; disabled bytes keep their old value. Takes effect at the acceptance edge; stays IDLE.
  - reg1 ADD (W): ACC <= ACC + masked operand (disabled bytes = 0). Sets status bit0 (carry) on unsigned overflow. Read returns last ADD/SUB operand.
  - reg2 SUB (W): ACC <= ACC - masked operand. Sets status bit1 (borrow) when operand > ACC. Read returns last operand.
  - reg3 STATUS (RW1C): bit0 carry, bit1 borrow, both sticky; other bits read 0. Writing 1 to an enabled bit clears it; byteenable applies.
- Arithmetic is modulo 2**DATASIZE.
- ADD/SUB timing: accepted at edge T -> waitrequest_o=1 from T until edge T+OP_CYCLES. ACC and flags update at edge T+OP_CYCLES. waitrequest_o=0 after that edge.
- Read timing: accepted at edge T -> readdatavalid_o=1 and readdata_o valid during the cycle after edge T+READ_LATENCY-1 (exactly one cycle). waitrequest_o stays 1 through that cycle, so a master holding read_i for one extra edge does not issue a second read. IDLE afterwards.
- Read data is sampled from registers at the acceptance edge.
- Out-of-range channel (chan >= NCHAN):
  - write accepted, no effect, no busy;
  - read follows normal latency and returns 0.
- Read of ADD/SUB/STATUS before any write returns 0.
- Fault injection:
  - ERRNO=1: borrow flag never set.
  - ERRNO=2: ACC write ignores byteenable.
  - ERRNO=3: readdatavalid_o asserted one cycle later, and waitrequest extended by one cycle.

Test Plan:
1. Reset, then read 0x0 with be=2'b11 -> readdatavalid_o high exactly 2 cycles after acceptance, readdata_o=0x0000. waitrequest_o high 3 cycles, readdatavalid_o high 1 cycle.
2. Write ACC 0x4=0x1234, then ADD 0x5=0x0010 -> waitrequest_o high 3 cycles after ADD acceptance. Read 0x4=0x1244; read 0x5=0x0010.
3. Byteenable:
   - Write ACC 0x8=0xFFFF.
   - Write 0x8=0xAB00 with be=2'b10 -> read 0xABFF.
   - ADD 0x9=0x1234 with be=2'b01 -> read ACC 0xAC33.
4. Flags:
   - ACC 0x0=0xFFFE; ADD 0x1=0x0003 -> ACC 0x0001, STATUS 0x0001.
   - SUB 0x2=0x0002 -> ACC 0xFFFF, STATUS 0x0003.
   - Write STATUS 0x3=0x0001 -> STATUS 0x0002.
5. Out-of-range (NCHAN=3): write 0xC=0x5555 -> no busy, channels unchanged. Read 0xD -> 0x0000 at normal latency.
6. Reset mid-op: ADD accepted, rst_i pulsed during the 2nd busy cycle -> waitrequest_o=0 immediately, all ACC read 0, no readdatavalid. Rerun tests 1-4 with ERRNO=1..3 -> the bench flags each fault.
